// File: rtl/rf_pkg.sv
// Shared FunSel encodings and bulk-clear sequencer states for the parameterised register file.
package rf_pkg;

  localparam logic [2:0] FS_CLR  = 3'b000;
  localparam logic [2:0] FS_LOAD = 3'b001;
  localparam logic [2:0] FS_INC  = 3'b010;
  localparam logic [2:0] FS_DEC  = 3'b011;
  localparam logic [2:0] FS_HOLD = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/rf_cell.sv
// One DATA_W storage cell: synchronous clear/load/increment/decrement/hold under an active-high enable.
module rf_cell #(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              E,
  input  logic [2:0]        FunSel,
  input  logic [DATA_W-1:0] I,
  output logic [DATA_W-1:0] Q
);
  import rf_pkg::*;

  logic [DATA_W-1:0] r_q;

  // Reset dominates; otherwise an enabled cell applies FunSel, wrapping on inc/dec.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_q <= '0;
    end else if (E) begin
      case (FunSel)
        FS_CLR:  r_q <= '0;
        FS_LOAD: r_q <= I;
        FS_INC:  r_q <= r_q + DATA_W'(1);
        FS_DEC:  r_q <= r_q - DATA_W'(1);
        default: r_q <= r_q;
      endcase
    end else begin
      r_q <= r_q;
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/param_reg_file.sv
// General + scratch register file with two read ports and a sequenced bulk clear.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module param_reg_file #(
  parameter  int DATA_W = 16,
  parameter  int NUM_R  = 4,
  parameter  int NUM_S  = 4,
  localparam int NUM_T  = NUM_R + NUM_S,
  localparam int SEL_W  = (NUM_T > 1) ? $clog2(NUM_T) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] I,
  input  logic [2:0]        FunSel,
  input  logic [NUM_R-1:0]  RegSel,
  input  logic [NUM_S-1:0]  ScrSel,
  input  logic [SEL_W-1:0]  OutASel,
  input  logic [SEL_W-1:0]  OutBSel,
  output logic [DATA_W-1:0] OutA,
  output logic [DATA_W-1:0] OutB,
  input  logic              ClrStart,
  output logic              ClrBusy,
  output logic              ClrDone
);
  import rf_pkg::*;

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic [SEL_W-1:0]  r_walk_idx;
  logic [SEL_W-1:0]  w_next_idx;
  logic              r_clr_busy;
  logic              r_clr_done;
  logic              w_busy;
  logic [NUM_T-1:0]  w_host_en;
  logic [NUM_T-1:0]  w_cell_en;
  logic [2:0]        w_cell_fun;
  logic [DATA_W-1:0] w_q  [NUM_T];
  logic [DATA_W-1:0] w_rd [NUM_T];
  logic [DATA_W-1:0] w_out_a;
  logic [DATA_W-1:0] w_out_b;

  // Host enables are active-low with the MSB of each select bus mapping to that bank's index 0.
  always_comb begin
    w_host_en = '0;
    for (int i = 0; i < NUM_R; i++) begin
      w_host_en[i] = ~RegSel[NUM_R-1-i];
    end
    for (int j = 0; j < NUM_S; j++) begin
      w_host_en[NUM_R+j] = ~ScrSel[NUM_S-1-j];
    end
  end

  assign w_busy     = (r_state == BUSY);
  assign w_cell_fun = w_busy ? FS_CLR : FunSel;

  // During the walk only the indexed cell is enabled, so host traffic is masked.
  always_comb begin
    w_cell_en = '0;
    for (int i = 0; i < NUM_T; i++) begin
      w_cell_en[i] = w_busy ? (r_walk_idx == SEL_W'(i)) : w_host_en[i];
    end
  end

  for (genvar g = 0; g < NUM_T; g++) begin : g_cell
    rf_cell #(.DATA_W(DATA_W)) u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .E      (w_cell_en[g]),
      .FunSel (w_cell_fun),
      .I      (I),
      .Q      (w_q[g])
    );
  end

`ifdef RF_BYPASS_EN
  // A same-cycle host load is forwarded to readers, except while the walk owns the cells.
  always_comb begin
    for (int i = 0; i < NUM_T; i++) begin
      w_rd[i] = (!w_busy && w_host_en[i] && (FunSel == FS_LOAD)) ? I : w_q[i];
    end
  end
`else
  // Readers see stored contents only.
  always_comb begin
    for (int i = 0; i < NUM_T; i++) begin
      w_rd[i] = w_q[i];
    end
  end
`endif

  // Read muxes; an index beyond the last register leaves the port at zero.
  always_comb begin
    w_out_a = '0;
    w_out_b = '0;
    for (int i = 0; i < NUM_T; i++) begin
      w_out_a = (OutASel == SEL_W'(i)) ? w_rd[i] : w_out_a;
      w_out_b = (OutBSel == SEL_W'(i)) ? w_rd[i] : w_out_b;
    end
  end

  assign OutA = w_out_a;
  assign OutB = w_out_b;

  // Sequencer state, walk index and the status flags registered from the next state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_walk_idx <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_walk_idx <= w_next_idx;
      r_clr_busy <= (w_next_state == BUSY);
      r_clr_done <= (w_next_state == DONE);
    end
  end

  // Next-state logic: start only from IDLE, walk every index once, then one DONE cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_walk_idx;
    case (r_state)
      IDLE: begin
        w_next_idx = '0;
        if (ClrStart) begin
          w_next_state = BUSY;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        if (r_walk_idx == SEL_W'(NUM_T - 1)) begin
          w_next_state = DONE;
          w_next_idx   = '0;
        end else begin
          w_next_state = BUSY;
          w_next_idx   = r_walk_idx + SEL_W'(1);
        end
      end
      DONE: begin
        w_next_state = IDLE;
        w_next_idx   = '0;
      end
      default: begin
        w_next_state = IDLE;
        w_next_idx   = '0;
      end
    endcase
  end

  assign ClrBusy = r_clr_busy;
  assign ClrDone = r_clr_done;

endmodule

// File: tb/tb_param_reg_file.sv
// Self-checking bench for param_reg_file: vector table, random host traffic against a model, clear sequences.
module tb_param_reg_file;

  localparam int DW = 16;
  localparam int NT = 8;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset;
  logic [DW-1:0] I;
  logic [2:0]    FunSel;
  logic [3:0]    RegSel;
  logic [3:0]    ScrSel;
  logic [2:0]    OutASel;
  logic [2:0]    OutBSel;
  logic [DW-1:0] OutA;
  logic [DW-1:0] OutB;
  logic          ClrStart;
  logic          ClrBusy;
  logic          ClrDone;

  int errors = 0;
  int checks = 0;
  int model [NT];

  param_reg_file dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .I        (I),
    .FunSel   (FunSel),
    .RegSel   (RegSel),
    .ScrSel   (ScrSel),
    .OutASel  (OutASel),
    .OutBSel  (OutBSel),
    .OutA     (OutA),
    .OutB     (OutB),
    .ClrStart (ClrStart),
    .ClrBusy  (ClrBusy),
    .ClrDone  (ClrDone)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]    regsel;
    logic [3:0]    scrsel;
    logic [2:0]    fun;
    logic [DW-1:0] din;
    logic [2:0]    asel;
    logic [2:0]    bsel;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_host();
    RegSel = 4'hF;
    ScrSel = 4'hF;
    FunSel = 3'b100;
  endtask

  task automatic read_all(input string name, input logic [DW-1:0] exp);
    for (int i = 0; i < NT; i++) begin
      OutASel = 3'(i);
      #1;
      check($sformatf("%s r%0d", name, i), OutA, exp);
    end
  endtask

  function automatic bit enabled(input int idx, input logic [3:0] rs, input logic [3:0] ss);
    if (idx < 4) return !rs[3-idx];
    return !ss[3-(idx-4)];
  endfunction

  function automatic int expect_read(input int idx);
    if (BYP && enabled(idx, RegSel, ScrSel) && FunSel == 3'b001) return int'(I);
    return model[idx];
  endfunction

  task automatic load_all(input logic [DW-1:0] v);
    RegSel = 4'h0; ScrSel = 4'h0; FunSel = 3'b001; I = v;
    step();
    idle_host();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int walks, dones, busy_cycles;
    logic prev_busy;

    Reset = 1'b1; ClrStart = 1'b0; I = '0; OutASel = '0; OutBSel = '0;
    idle_host();
    step(); step();
    Reset = 1'b0;
    #1;
    check("reset OutA", OutA, 16'h0000);
    check("reset ClrBusy", ClrBusy, 1'b0);
    check("reset ClrDone", ClrDone, 1'b0);

    // Hand-computed vectors from the all-zero state; each is applied for one edge.
    vecs[0]  = '{4'b0111, 4'b1111, 3'b001, 16'hA5A5, 3'd0, 3'd1, 16'hA5A5, 16'h0000};
    vecs[1]  = '{4'b1011, 4'b1111, 3'b001, 16'hFFFF, 3'd1, 3'd0, 16'hFFFF, 16'hA5A5};
    vecs[2]  = '{4'b1011, 4'b1111, 3'b010, 16'h0000, 3'd1, 3'd0, 16'h0000, 16'hA5A5};
    vecs[3]  = '{4'b1011, 4'b1111, 3'b011, 16'h0000, 3'd1, 3'd2, 16'hFFFF, 16'h0000};
    vecs[4]  = '{4'b1111, 4'b0000, 3'b001, 16'h1234, 3'd4, 3'd7, 16'h1234, 16'h1234};
    vecs[5]  = '{4'b1111, 4'b0101, 3'b010, 16'h0000, 3'd4, 3'd5, 16'h1235, 16'h1234};
    vecs[6]  = '{4'b0000, 4'b1111, 3'b100, 16'hFFFF, 3'd0, 3'd1, 16'hA5A5, 16'hFFFF};
    vecs[7]  = '{4'b0101, 4'b1111, 3'b011, 16'h0000, 3'd0, 3'd2, 16'hA5A4, 16'hFFFF};
    vecs[8]  = '{4'b1111, 4'b1111, 3'b001, 16'h0000, 3'd6, 3'd7, 16'h1235, 16'h1234};
    vecs[9]  = '{4'b1110, 4'b1111, 3'b001, 16'h0F0F, 3'd3, 3'd3, 16'h0F0F, 16'h0F0F};
    vecs[10] = '{4'b1110, 4'b1111, 3'b000, 16'h0000, 3'd3, 3'd4, 16'h0000, 16'h1235};
    vecs[11] = '{4'b0000, 4'b0000, 3'b111, 16'h5555, 3'd0, 3'd6, 16'hA5A4, 16'h1235};

    for (int v = 0; v < 12; v++) begin
      RegSel = vecs[v].regsel; ScrSel = vecs[v].scrsel; FunSel = vecs[v].fun; I = vecs[v].din;
      step();
      idle_host();
      OutASel = vecs[v].asel; OutBSel = vecs[v].bsel;
      #1;
      check($sformatf("vec%0d OutA", v), OutA, vecs[v].exp_a);
      check($sformatf("vec%0d OutB", v), OutB, vecs[v].exp_b);
    end

    // Random host traffic against an arithmetic model of the register contents.
    Reset = 1'b1; step(); Reset = 1'b0;
    for (int i = 0; i < NT; i++) model[i] = 0;
    for (int n = 0; n < 200; n++) begin
      RegSel = 4'($urandom); ScrSel = 4'($urandom); FunSel = 3'($urandom);
      I = 16'($urandom); OutASel = 3'($urandom_range(7, 0)); OutBSel = 3'($urandom_range(7, 0));
      #1;
      check($sformatf("rand%0d OutA", n), OutA, expect_read(int'(OutASel)));
      check($sformatf("rand%0d OutB", n), OutB, expect_read(int'(OutBSel)));
      for (int i = 0; i < NT; i++) begin
        if (enabled(i, RegSel, ScrSel)) begin
          case (FunSel)
            3'b000:  model[i] = 0;
            3'b001:  model[i] = int'(I);
            3'b010:  model[i] = (model[i] + 1) % 65536;
            3'b011:  model[i] = (model[i] + 65535) % 65536;
            default: model[i] = model[i];
          endcase
        end
      end
      step();
    end
    idle_host();
    for (int i = 0; i < NT; i++) begin
      OutASel = 3'(i);
      #1;
      check($sformatf("rand final r%0d", i), OutA, model[i]);
    end

    // Bulk clear walk with host loads attempted while busy.
    load_all(16'h1234);
    #1;
    check("walk pre ClrBusy", ClrBusy, 1'b0);
    ClrStart = 1'b1;
    step();
    ClrStart = 1'b0;
    RegSel = 4'h0; ScrSel = 4'h0; FunSel = 3'b001; I = 16'hBEEF;
    for (int k = 0; k < NT; k++) begin
      if (k == NT - 1) idle_host();
      OutASel = 3'(k); OutBSel = 3'd7;
      #1;
      check($sformatf("walk%0d ClrBusy", k), ClrBusy, 1'b1);
      check($sformatf("walk%0d before", k), OutA, 16'h1234);
      check($sformatf("walk%0d last reg", k), OutB, 16'h1234);
      step();
      check($sformatf("walk%0d cleared", k), OutA, 16'h0000);
    end
    check("walk end ClrBusy", ClrBusy, 1'b0);
    check("walk end ClrDone", ClrDone, 1'b1);
    step();
    check("walk after ClrDone", ClrDone, 1'b0);
    read_all("walk all zero", 16'h0000);

    // ClrStart held for 20 edges: exactly two walks, DONE requests ignored.
    walks = 0; dones = 0; busy_cycles = 0; prev_busy = ClrBusy;
    ClrStart = 1'b1;
    for (int s = 0; s < 40; s++) begin
      if (s == 20) ClrStart = 1'b0;
      step();
      if (ClrBusy && !prev_busy) walks++;
      if (ClrDone) dones++;
      if (ClrBusy) busy_cycles++;
      prev_busy = ClrBusy;
    end
    check("held walks", walks, 2);
    check("held dones", dones, 2);
    check("held busy cycles", busy_cycles, 16);

    // Reset in the middle of a walk aborts it without a done pulse.
    load_all(16'h1234);
    ClrStart = 1'b1;
    step();
    ClrStart = 1'b0;
    step(); step(); step();
    check("abort at idx3 busy", ClrBusy, 1'b1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("abort ClrBusy", ClrBusy, 1'b0);
    check("abort ClrDone", ClrDone, 1'b0);
    read_all("abort zero", 16'h0000);
    dones = 0;
    for (int s = 0; s < 10; s++) begin
      step();
      if (ClrDone || ClrBusy) dones++;
    end
    check("abort no done", dones, 0);

    // Same-cycle forwarding on a scratch register (index 5).
    RegSel = 4'hF; ScrSel = 4'b1011; FunSel = 3'b001; I = 16'h1111;
    step();
    idle_host();
    ScrSel = 4'b1011; FunSel = 3'b001; I = 16'h00FF; OutBSel = 3'd5;
    #1;
    check("bypass same cycle", OutB, BYP ? 16'h00FF : 16'h1111);
    step();
    idle_host();
    #1;
    check("bypass after edge", OutB, 16'h00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
